shift_arbiter: RTL
==================

SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 The module SHALL use one clock; reset is synchronous and active-low.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-004 reqN_valid  in  1  requester N (N=0,1) presents a request.
REQ-005 reqN_ready  out  1  module accepts requester N this cycle.
REQ-006 reqN_op  in  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 PASS (data returned unchanged).
REQ-007 reqN_data  in  32  operand.
REQ-008 reqN_shamt  in  5  shift amount, 0..31.
REQ-009 rsp_valid  out  1  response available.
REQ-010 rsp_ready  in  1  consumer accepts the response.
REQ-011 rsp_id  out  1  index of the requester that owns the response.
REQ-012 rsp_data  out  32  result.
REQ-013 The module SHALL contain exactly one instance of the team's 32-bit left shifter (dataA 32, dataB 5, dataOut = dataA << dataB, zero fill), and all shift operations SHALL be performed through it.

Function
REQ-014 FSM states: IDLE, PASS1, PASS2, RESP.
REQ-015 Handshakes: a transfer occurs when valid && ready. Ready SHALL depend only on state, the valids and the last-grant register.
REQ-016 Arbitration, in IDLE only:
 - grant0 = req0_valid && (!req1_valid || last_grant==1).
 - grant1 = req1_valid && !grant0.
 - reqN_ready = (state==IDLE) && grantN.
 - In every state other than IDLE, both readys SHALL be 0.
REQ-017 On a transfer, the module SHALL:
 - latch op, data, shamt and id;
 - set last_grant to the granted id;
 - go to PASS1.
REQ-018 PASS1, by op:
 - SLL: shifter input = data, amount = shamt.
 - SRL and SRA: shifter input = bitreverse(data), amount = shamt; result = bitreverse(shifter output).
 - PASS: amount forced to 0.
 - The result SHALL be registered at the end of PASS1.
REQ-019 PASS1 exit: go to PASS2 if op==SRA and data[31]==1, including shamt==0; otherwise go to RESP.
REQ-020 PASS2 SHALL:
 - drive shifter input = 32'hFFFF_FFFF, amount = shamt;
 - form mask = bitreverse(~shifter output), i.e. the top shamt bits set;
 - register result | mask;
 - go to RESP.
REQ-021 RESP SHALL:
 - hold rsp_valid=1 with rsp_id and rsp_data stable until rsp_ready==1;
 - on that edge, go to IDLE.
REQ-022 rsp_valid SHALL be 1 only in RESP.
REQ-023 Latency from accept edge to rsp_valid: 2 cycles for single-pass ops; 3 cycles for SRA with a negative operand.
REQ-024 A new request SHALL NOT be accepted in the cycle in which the response handshake completes; the next accept occurs in IDLE one cycle later.
REQ-025 If both requesters stay valid, grants SHALL strictly alternate. A requester waiting while the other is served SHALL win the next arbitration.
REQ-026 Requester inputs SHALL be ignored outside the transfer cycle; changing them after accept SHALL NOT affect the result.

Reset
REQ-027 While rst_n==0 at a clock edge, the next state SHALL be:
 - state IDLE, last_grant 1 (requester 0 wins the first contest);
 - rsp_valid 0, rsp_id 0, rsp_data 0;
 - latched operands 0.
REQ-028 Reset in any state SHALL discard the in-flight request without producing a response.
REQ-029 Reset SHALL override a simultaneous request or response handshake in the same cycle.

Verification
REQ-030 req0 SLL data 0x0000_0001 shamt 31 -> rsp_valid 2 cycles after accept, rsp_id 0, rsp_data 0x8000_0000.
REQ-031 req1 SRL data 0x8000_0000 shamt 4 -> rsp_id 1, rsp_data 0x0800_0000, 2-cycle latency.
REQ-032 SRA data 0xF000_0000 shamt 4 -> rsp_data 0xFF00_0000 after 3 cycles.
 - SRA 0x7000_0000 shamt 4 -> 0x0700_0000 after 2 cycles.
 - SRA 0x8000_0000 shamt 31 -> 0xFFFF_FFFF.
 - SRA 0x8000_0000 shamt 0 -> 0x8000_0000.
REQ-033 req0 and req1 continuously valid, rsp_ready=1 -> rsp_id sequence 0,1,0,1,... and readys never both high.
REQ-034 rsp_ready held 0 for 5 cycles in RESP -> rsp_valid, rsp_id and rsp_data stable, both readys 0; release -> IDLE next cycle.
REQ-035 rst_n=0 during PASS2 -> rsp_valid 0 and state IDLE after that edge, no response emitted; next contention grants requester 0.

Source files
------------

// File: rtl/shift_arbiter.sv
// Two-requester round-robin front end for a single shared 32-bit left shifter.
// Right shifts go through the shifter by bit reversal; an arithmetic shift of a negative operand uses a second mask pass.

module shift_left32 (
    input  logic [31:0] dataA,
    input  logic [4:0]  dataB,
    output logic [31:0] dataOut
);
    assign dataOut = dataA << dataB;
endmodule

// state | meaning
// IDLE  | arbitrate between requesters, accept one transfer
// PASS1 | main shift pass, result registered
// PASS2 | sign-fill mask pass for SRA of a negative operand
// RESP  | hold response until rsp_ready
module shift_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [1:0]  req0_op,
    input  logic [31:0] req0_data,
    input  logic [4:0]  req0_shamt,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [1:0]  req1_op,
    input  logic [31:0] req1_data,
    input  logic [4:0]  req1_shamt,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_data
);
    typedef enum logic [1:0] {IDLE, PASS1, PASS2, RESP} state_t;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] data_q, data_d;
    logic [4:0]  shamt_q, shamt_d;
    logic        id_q, id_d;
    logic [31:0] result_q, result_d;

    logic        grant0, grant1;
    logic [31:0] sh_a;
    logic [4:0]  sh_b;
    logic [31:0] sh_out;

    function automatic logic [31:0] bit_rev(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = x[31-i];
        return r;
    endfunction

    shift_left32 u_shl (
        .dataA  (sh_a),
        .dataB  (sh_b),
        .dataOut(sh_out)
    );

    // Requester 0 wins unless requester 1 also asks and 0 was served last.
    always_comb begin
        grant0     = req0_valid && (!req1_valid || last_grant_q);
        grant1     = req1_valid && !grant0;
        req0_ready = (state_q == IDLE) && grant0;
        req1_ready = (state_q == IDLE) && grant1;
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_d         = op_q;
        data_d       = data_q;
        shamt_d      = shamt_q;
        id_d         = id_q;
        result_d     = result_q;
        sh_a         = 32'h0;
        sh_b         = 5'd0;

        case (state_q)
            IDLE: begin
                if (grant0) begin
                    op_d         = req0_op;
                    data_d       = req0_data;
                    shamt_d      = req0_shamt;
                    id_d         = 1'b0;
                    last_grant_d = 1'b0;
                    state_d      = PASS1;
                end else if (grant1) begin
                    op_d         = req1_op;
                    data_d       = req1_data;
                    shamt_d      = req1_shamt;
                    id_d         = 1'b1;
                    last_grant_d = 1'b1;
                    state_d      = PASS1;
                end
            end
            PASS1: begin
                case (op_q)
                    OP_SLL: begin
                        sh_a     = data_q;
                        sh_b     = shamt_q;
                        result_d = sh_out;
                    end
                    OP_SRL, OP_SRA: begin
                        sh_a     = bit_rev(data_q);
                        sh_b     = shamt_q;
                        result_d = bit_rev(sh_out);
                    end
                    default: begin
                        sh_a     = data_q;
                        sh_b     = 5'd0;
                        result_d = sh_out;
                    end
                endcase
                state_d = ((op_q == OP_SRA) && data_q[31]) ? PASS2 : RESP;
            end
            PASS2: begin
                // Ones shifted left leave shamt zeros at the bottom; inverted and reversed that is the sign fill.
                sh_a     = 32'hFFFF_FFFF;
                sh_b     = shamt_q;
                result_d = result_q | bit_rev(~sh_out);
                state_d  = RESP;
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            op_q         <= 2'b00;
            data_q       <= 32'h0;
            shamt_q      <= 5'd0;
            id_q         <= 1'b0;
            result_q     <= 32'h0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_q         <= op_d;
            data_q       <= data_d;
            shamt_q      <= shamt_d;
            id_q         <= id_d;
            result_q     <= result_d;
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = id_q;
    assign rsp_data  = result_q;

endmodule
